px_adc_reader: RTL and testbench
================================

// Module: px_adc_reader
// PURPOSE
//  Serial-ADC front end for one Stonyman camera pixel chain. On a start request it runs one
//  conversion frame on the external 12-bit pixel ADC (cam*_px_adc_cs / _sclk / px*_adc_din).
//  It returns the 12-bit sample with a one-cycle valid strobe.
//  Sits between the camera scan sequencer (upstream, issues start) and the frame-capture/PSRAM path.
// PARAMETERS
//  CLK_DIV       2   clk cycles per SCLK half-period; legal range 1..15
//  QUIET_CYCLES  3   clk cycles CS held high after a frame before busy drops (ADC tQUIET); legal range 1..15
//  FRAME_BITS    16  SCLK cycles per frame: 4 leading zeros then 12 data bits, MSB first; fixed
// PORTS
//  clk           in   1   system clock, single domain
//  reset_n       in   1   synchronous, active-low reset
//  start         in   1   conversion request; accepted only when busy==0
//  busy          out  1   high from the cycle after an accepted start until the quiet period ends
//  adc_cs_n      out  1   ADC chip select, active low
//  adc_sclk      out  1   ADC serial clock; idles high
//  adc_din       in   1   ADC serial data; already synchronised by the top level
//  sample        out  12  last completed sample; holds its value until the next frame completes
//  sample_valid  out  1   one-cycle strobe; sample and fmt_err are valid in that cycle
//  fmt_err       out  1   the 4 leading bits of the last frame were not all zero
// BEHAVIOUR
//  Reset values: adc_cs_n=1, adc_sclk=1, busy=0, sample_valid=0, sample=12'h000, fmt_err=0, FSM=IDLE.
//  All outputs are registered; no combinational path from an input to an output.
//  FSM states: IDLE -> SETUP -> (LOW <-> HIGH) x16 -> QUIET -> IDLE.
//   IDLE : start=1 at cycle T -> SETUP at T+1. In SETUP: cs_n=0, sclk=1, busy=1.
//   SETUP: lasts CLK_DIV cycles (CS-to-SCLK setup) -> LOW.
//   LOW  : sclk=0 for CLK_DIV cycles. adc_din is shifted into a 16-bit shift register (MSB first)
//          on the last cycle of LOW, i.e. on the clk edge where sclk returns high.
//   HIGH : sclk=1 for CLK_DIV cycles; bit counter increments. After bit 15 -> QUIET, else -> LOW.
//   QUIET: cs_n=1, sclk=1, busy=1 for QUIET_CYCLES cycles -> IDLE (busy=0).
//  On the first QUIET cycle: sample_valid=1, sample=shift[11:0], fmt_err=|shift[15:12].
//  Timing: cs_n is low for 33*CLK_DIV cycles (T+1 .. T+33*CLK_DIV).
//   sample_valid at T+33*CLK_DIV+1; busy low at T+33*CLK_DIV+1+QUIET_CYCLES.
//  start while busy=1 is ignored and is not queued.
//  start in the same cycle busy falls is accepted: next SETUP begins the following cycle.
//  Back-to-back frame period: 33*CLK_DIV + QUIET_CYCLES + 1 cycles.
//  reset_n low mid-frame: on the next clk, cs_n=1 and sclk=1 immediately; FSM goes to IDLE;
//   no sample_valid; sample is cleared to 0. No quiet period is enforced after reset.
//  Counters: div counter 4 bits, saturating compare to CLK_DIV-1; bit counter 4 bits,
//   terminal count 15, no wrap beyond it.
// STRUCTURE
//  Shared include senseye_defs.vh holds:
//   - PX_ADC_FRAME_BITS=16, PX_ADC_DATA_BITS=12, PX_ADC_LEAD_BITS=4
//   - FSM state encodings PXA_IDLE..PXA_QUIET (3-bit)
//  One instance per camera (cam0, cam1) in TOPLEVEL. No sub-modules: FSM, divider and shifter in one file.
// TESTING
//  1 CLK_DIV=2, QUIET=3; din models an ADC returning 16'h0A5C; start at T
//    -> cs_n low T+1..T+66, sample_valid at T+67 with sample=12'hA5C, fmt_err=0, busy low at T+70.
//  2 Pulse start at T+10 and again at T+40 during frame 1 -> only one frame on the pins;
//    exactly one sample_valid.
//  3 Hold start high continuously -> frames repeat every 70 cycles; cs_n high for exactly 4 cycles between frames.
//  4 ADC returns 16'h8FFF -> sample=12'hFFF, fmt_err=1; the following frame with 16'h0001
//    -> sample=12'h001, fmt_err=0.
//  5 reset_n low at T+30 for 1 cycle -> cs_n=1 and sclk=1 at T+31, no sample_valid, sample=0;
//    a new start at T+35 runs a normal frame.
//  6 CLK_DIV=1, QUIET=1 -> sclk period 2 cycles, cs_n low 33 cycles, sample_valid at T+34;
//    checker counts exactly 16 sclk rising edges per frame.

Source files
------------

// File: rtl/px_adc_reader_pkg.sv
// Shared constants and FSM encoding for the Stonyman pixel serial-ADC reader.
package px_adc_reader_pkg;

   localparam int PX_ADC_FRAME_BITS = 16;
   localparam int PX_ADC_DATA_BITS  = 12;
   localparam int PX_ADC_LEAD_BITS  = 4;

   typedef enum logic [2:0] {
      PXA_IDLE  = 3'd0,
      PXA_SETUP = 3'd1,
      PXA_LOW   = 3'd2,
      PXA_HIGH  = 3'd3,
      PXA_QUIET = 3'd4
   } pxa_state_e;

endpackage

// File: rtl/px_adc_reader.sv
// Runs one 16-SCLK conversion frame on the external pixel ADC per accepted start
// and returns the 12-bit sample with a one-cycle valid strobe.
module px_adc_reader
   import px_adc_reader_pkg::*;
#(
   parameter int unsigned CLK_DIV      = 2,
   parameter int unsigned QUIET_CYCLES = 3
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   output logic                        busy,
   output logic                        adc_cs_n,
   output logic                        adc_sclk,
   input  logic                        adc_din,
   output logic [PX_ADC_DATA_BITS-1:0] sample,
   output logic                        sample_valid,
   output logic                        fmt_err,
   output pxa_state_e                  dbg_state
);

   localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
   localparam logic [3:0] QUIET_LAST = 4'(QUIET_CYCLES - 1);
   localparam logic [3:0] BIT_LAST   = 4'(PX_ADC_FRAME_BITS - 1);

   pxa_state_e                   state_q, state_d;
   logic [3:0]                   div_q, div_d;
   logic [3:0]                   bit_q, bit_d;
   logic [PX_ADC_FRAME_BITS-1:0] shift_q, shift_d;
   logic [PX_ADC_DATA_BITS-1:0]  sample_d;
   logic                         valid_d, err_d;
   logic                         div_done;

   // Handshake: start is taken only in a cycle where busy is low (IDLE); it is
   // never queued, and busy rises in the following cycle.
   assign div_done  = (div_q >= DIV_LAST);
   assign dbg_state = state_q;

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      sample_d = sample;
      valid_d  = 1'b0;
      err_d    = fmt_err;
      case (state_q)
         PXA_IDLE: begin
            if (start) begin
               state_d = PXA_SETUP;
               div_d   = 4'd0;
               bit_d   = 4'd0;
            end
         end
         PXA_SETUP: begin
            if (div_done) begin
               state_d = PXA_LOW;
               div_d   = 4'd0;
            end else begin
               div_d = div_q + 4'd1;
            end
         end
         PXA_LOW: begin
            // Sample on the edge where SCLK returns high.
            if (div_done) begin
               shift_d = {shift_q[PX_ADC_FRAME_BITS-2:0], adc_din};
               state_d = PXA_HIGH;
               div_d   = 4'd0;
            end else begin
               div_d = div_q + 4'd1;
            end
         end
         PXA_HIGH: begin
            if (div_done) begin
               div_d = 4'd0;
               if (bit_q == BIT_LAST) begin
                  state_d  = PXA_QUIET;
                  valid_d  = 1'b1;
                  sample_d = shift_q[PX_ADC_DATA_BITS-1:0];
                  err_d    = |shift_q[PX_ADC_FRAME_BITS-1 -: PX_ADC_LEAD_BITS];
               end else begin
                  bit_d   = bit_q + 4'd1;
                  state_d = PXA_LOW;
               end
            end else begin
               div_d = div_q + 4'd1;
            end
         end
         PXA_QUIET: begin
            if (div_q >= QUIET_LAST) begin
               state_d = PXA_IDLE;
               div_d   = 4'd0;
            end else begin
               div_d = div_q + 4'd1;
            end
         end
         default: state_d = PXA_IDLE;
      endcase
   end

   // Pin outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= PXA_IDLE;
         div_q        <= 4'd0;
         bit_q        <= 4'd0;
         shift_q      <= '0;
         sample       <= '0;
         sample_valid <= 1'b0;
         fmt_err      <= 1'b0;
         busy         <= 1'b0;
         adc_cs_n     <= 1'b1;
         adc_sclk     <= 1'b1;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         sample       <= sample_d;
         sample_valid <= valid_d;
         fmt_err      <= err_d;
         busy         <= (state_d != PXA_IDLE);
         adc_cs_n     <= !(state_d inside {PXA_SETUP, PXA_LOW, PXA_HIGH});
         adc_sclk     <= (state_d != PXA_LOW);
      end
   end

endmodule

// File: tb/tb_px_adc_reader.sv
// Bench for px_adc_reader: an ADC pin model feeds both a CLK_DIV=2/QUIET=3 and a
// CLK_DIV=1/QUIET=1 instance; returned samples are scored against the words sent.
module tb_px_adc_reader;
   import px_adc_reader_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  start = 2'b00;
   logic [1:0]  busy, adc_cs_n, adc_sclk, adc_din, sample_valid, fmt_err;
   logic [11:0] sample0, sample1;
   pxa_state_e  dbg0, dbg1;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   logic [15:0] word0 = 16'h0, word1 = 16'h0, cur0 = 16'h0, cur1 = 16'h0;
   logic [15:0] e0, e1;
   int          rise0 = 0, rise1 = 0, last_rise0 = 0, last_rise1 = 0;
   logic [15:0] exp_q0[$];
   logic [15:0] exp_q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   px_adc_reader #(.CLK_DIV(2), .QUIET_CYCLES(3)) dut0 (
      .clk(clk), .reset_n(reset_n), .start(start[0]), .busy(busy[0]),
      .adc_cs_n(adc_cs_n[0]), .adc_sclk(adc_sclk[0]), .adc_din(adc_din[0]),
      .sample(sample0), .sample_valid(sample_valid[0]), .fmt_err(fmt_err[0]),
      .dbg_state(dbg0)
   );

   px_adc_reader #(.CLK_DIV(1), .QUIET_CYCLES(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start[1]), .busy(busy[1]),
      .adc_cs_n(adc_cs_n[1]), .adc_sclk(adc_sclk[1]), .adc_din(adc_din[1]),
      .sample(sample1), .sample_valid(sample_valid[1]), .fmt_err(fmt_err[1]),
      .dbg_state(dbg1)
   );

   // ADC pin model: latches a word when CS falls, presents bit (15 - rises) on DIN,
   // where rises counts SCLK rising edges seen since CS fell.
   always @(negedge adc_cs_n[0]) begin cur0 = word0; rise0 = 0; exp_q0.push_back(word0); end
   always @(posedge adc_cs_n[0]) last_rise0 = rise0;
   always @(posedge adc_sclk[0]) if (adc_cs_n[0] === 1'b0) rise0 = rise0 + 1;
   assign adc_din[0] = (adc_cs_n[0] === 1'b0 && rise0 < 16) ? cur0[4'(15 - rise0)] : 1'b0;

   always @(negedge adc_cs_n[1]) begin cur1 = word1; rise1 = 0; exp_q1.push_back(word1); end
   always @(posedge adc_cs_n[1]) last_rise1 = rise1;
   always @(posedge adc_sclk[1]) if (adc_cs_n[1] === 1'b0) rise1 = rise1 + 1;
   assign adc_din[1] = (adc_cs_n[1] === 1'b0 && rise1 < 16) ? cur1[4'(15 - rise1)] : 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every strobe must match the oldest word the ADC model sent.
   always @(negedge clk) begin
      if (sample_valid[0] === 1'b1) begin
         check("sb0_expected", 32'(exp_q0.size() > 0), 32'd1);
         if (exp_q0.size() > 0) begin
            e0 = exp_q0.pop_front();
            check("sb0_sample", 32'(sample0), 32'(e0[11:0]));
            check("sb0_fmt_err", 32'(fmt_err[0]), 32'(|e0[15:12]));
         end
      end
      if (sample_valid[1] === 1'b1) begin
         check("sb1_expected", 32'(exp_q1.size() > 0), 32'd1);
         if (exp_q1.size() > 0) begin
            e1 = exp_q1.pop_front();
            check("sb1_sample", 32'(sample1), 32'(e1[11:0]));
            check("sb1_fmt_err", 32'(fmt_err[1]), 32'(|e1[15:12]));
         end
      end
   end

   // One frame on instance w starting in the current cycle T; optional extra start
   // pulses at T+p1 / T+p2 must be ignored. Pin timing is derived from d and q.
   task automatic run_frame(input int w, input int d, input int q, input logic [15:0] word,
                            input int p1, input int p2, input string tag);
      int t, first_low, last_low, low_n, falls, valid_at, valid_n, busy_low;
      logic seen_busy, prev_cs;
      if (w == 0) word0 = word; else word1 = word;
      t = cyc; first_low = -1; last_low = -1; low_n = 0; falls = 0;
      valid_at = -1; valid_n = 0; busy_low = -1; seen_busy = 1'b0; prev_cs = 1'b1;
      start[w] = 1'b1;
      for (int i = 1; i <= 33*d + q + 3; i++) begin
         @(negedge clk);
         start[w] = (i == p1 || i == p2);
         if (adc_cs_n[w] === 1'b0) begin
            if (first_low < 0) first_low = cyc - t;
            last_low = cyc - t;
            low_n++;
            if (prev_cs) falls++;
         end
         prev_cs = adc_cs_n[w];
         if (sample_valid[w] === 1'b1) begin
            valid_n++;
            if (valid_at < 0) valid_at = cyc - t;
         end
         if (busy[w] === 1'b1) seen_busy = 1'b1;
         else if (seen_busy && busy_low < 0) busy_low = cyc - t;
      end
      start[w] = 1'b0;
      check({tag, "_cs_first"}, 32'(first_low), 32'd1);
      check({tag, "_cs_last"},  32'(last_low), 32'(33*d));
      check({tag, "_cs_len"},   32'(low_n), 32'(33*d));
      check({tag, "_cs_falls"}, 32'(falls), 32'd1);
      check({tag, "_valid_at"}, 32'(valid_at), 32'(33*d + 1));
      check({tag, "_valid_n"},  32'(valid_n), 32'd1);
      check({tag, "_busy_low"}, 32'(busy_low), 32'(33*d + q + 1));
      check({tag, "_sclk_rises"}, 32'((w == 0) ? last_rise0 : last_rise1), 32'd16);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, valid_n, hi_run, timeout_ok;
      int fall_q[$];
      int gap_q[$];
      logic prev_cs;
      logic [15:0] w;

      // Reset state
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cs_n",  32'(adc_cs_n), 32'h3);
      check("rst_sclk",  32'(adc_sclk), 32'h3);
      check("rst_busy",  32'(busy), 32'h0);
      check("rst_valid", 32'(sample_valid), 32'h0);
      check("rst_fmt",   32'(fmt_err), 32'h0);
      check("rst_sample0", 32'(sample0), 32'h0);
      check("rst_state0", 32'(dbg0), 32'(PXA_IDLE));
      check("rst_state1", 32'(dbg1), 32'(PXA_IDLE));
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed frames with known words, plus ignored start pulses mid-frame
      run_frame(0, 2, 3, 16'h0A5C, 0, 0, "t1");
      check("t1_hold_sample", 32'(sample0), 32'h0A5C);
      run_frame(0, 2, 3, 16'h0123, 10, 40, "t2");
      run_frame(0, 2, 3, 16'h8FFF, 0, 0, "t4a");
      check("t4a_hold_err", 32'(fmt_err[0]), 32'd1);
      run_frame(0, 2, 3, 16'h0001, 0, 0, "t4b");
      check("t4b_hold_sample", 32'(sample0), 32'h001);
      check("t4b_hold_err", 32'(fmt_err[0]), 32'd0);

      // Randomised words, leading nibble random too
      for (int k = 0; k < 4; k++) run_frame(0, 2, 3, 16'($urandom), 0, 0, "rnd0");

      // Continuous start: back-to-back frames with a 4-cycle CS-high gap
      word0 = 16'($urandom);
      t = cyc; prev_cs = 1'b1; hi_run = 0;
      start[0] = 1'b1;
      for (int i = 1; i <= 215; i++) begin
         @(negedge clk);
         if (adc_cs_n[0] === 1'b0 && prev_cs) begin
            if (fall_q.size() > 0) gap_q.push_back(hi_run);
            fall_q.push_back(cyc - t);
            word0 = 16'($urandom);
            hi_run = 0;
         end else if (adc_cs_n[0] === 1'b1) begin
            hi_run++;
         end
         prev_cs = adc_cs_n[0];
      end
      start[0] = 1'b0;
      check("t3_frames", 32'(fall_q.size()), 32'd4);
      if (fall_q.size() == 4) begin
         check("t3_first", 32'(fall_q[0]), 32'd1);
         check("t3_period_a", 32'(fall_q[1] - fall_q[0]), 32'd70);
         check("t3_period_b", 32'(fall_q[3] - fall_q[2]), 32'd70);
         foreach (gap_q[g]) check("t3_gap", 32'(gap_q[g]), 32'd4);
      end
      timeout_ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (busy[0] === 1'b0) begin timeout_ok = 1; break; end
      end
      check("t3_drain", 32'(timeout_ok), 32'd1);
      @(negedge clk);
      check("t3_sb_empty", 32'(exp_q0.size()), 32'd0);

      // Reset mid-frame: pins return to idle at once and the frame is dropped
      run_frame(0, 2, 3, {4'h0, 12'($urandom_range(1, 4095))}, 0, 0, "pre5");
      w = {4'h0, 12'($urandom_range(1, 4095))};
      word0 = w;
      t = cyc; valid_n = 0;
      start[0] = 1'b1;
      for (int i = 1; i <= 35; i++) begin
         @(negedge clk);
         start[0] = 1'b0;
         if (sample_valid[0] === 1'b1) valid_n++;
         if (i == 29) check("t5_sample_before", 32'(sample0 != 12'h000), 32'd1);
         reset_n = (i != 30);
         if (i == 30) exp_q0.delete();
         if (i == 31) begin
            check("t5_cs_n", 32'(adc_cs_n[0]), 32'd1);
            check("t5_sclk", 32'(adc_sclk[0]), 32'd1);
            check("t5_sample", 32'(sample0), 32'h000);
            check("t5_busy", 32'(busy[0]), 32'd0);
            check("t5_state", 32'(dbg0), 32'(PXA_IDLE));
         end
      end
      check("t5_no_valid", 32'(valid_n), 32'd0);
      run_frame(0, 2, 3, 16'($urandom), 0, 0, "t5_after");

      // Fastest divider and shortest quiet period
      run_frame(1, 1, 1, 16'h0A5C, 0, 0, "t6");
      for (int k = 0; k < 3; k++) run_frame(1, 1, 1, 16'($urandom), 7, 20, "rnd1");
      @(negedge clk);
      check("sb_empty0", 32'(exp_q0.size()), 32'd0);
      check("sb_empty1", 32'(exp_q1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
